// File: rtl/fb_pixel_writer.sv
// Pixel-stream sink: buffers linear pixel addresses in a small FIFO and commits them
// to a 1-bpp frame buffer SRAM through a one-word write-back cache.
module fb_pixel_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic [18:0] pix_addr,
  input  logic        pix_color,
  output logic        pix_ready,
  input  logic        prim_done,
  output logic        busy,
  output logic        frame_done,
  output logic [13:0] mem_addr,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_wdata
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [19:0] LIMIT = 20'(NUM_PIXELS);

  typedef struct packed {
    logic [13:0] word;
    logic [4:0]  bidx;
    logic        color;
  } pix_t;

  typedef enum logic [2:0] {IDLE, WB, READ, RDWAIT, FLUSH, DONE} state_t;

  state_t      state, state_n;
  pix_t        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        push, pop, fifo_ne, hit;
  pix_t        head, pend;
  logic [13:0] tag;
  logic [31:0] data, rd_merge;
  logic        valid, dirty, done_pend;

  assign pix_ready = (count != FULL);
  assign fifo_ne   = (count != '0);
  // Out-of-range pixels complete the handshake but never enter the FIFO.
  assign push      = pix_valid && pix_ready && ({1'b0, pix_addr} < LIMIT);
  assign head      = fifo_mem[rd_ptr];
  assign hit       = valid && (tag == head.word);
  assign pop       = (state == IDLE) && fifo_ne;
  assign busy      = fifo_ne || (state != IDLE) || done_pend;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{word: pix_addr[18:5], bidx: pix_addr[4:0], color: pix_color};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_ne) begin
          if (!hit) state_n = dirty ? WB : READ;
        end else if (done_pend) begin
          state_n = dirty ? FLUSH : DONE;
        end
      end
      WB: begin
        mem_wen   = 1'b1;
        mem_addr  = tag;
        mem_wdata = data;
        state_n   = READ;
      end
      READ: begin
        mem_ren  = 1'b1;
        mem_addr = pend.word;
        state_n  = RDWAIT;
      end
      RDWAIT: state_n = IDLE;
      FLUSH: begin
        mem_wen   = 1'b1;
        mem_addr  = tag;
        mem_wdata = data;
        state_n   = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_merge = mem_rdata;
    rd_merge[pend.bidx] = pend.color;
  end

  // Cache and pending-pixel registers; data/tag need no reset because valid gates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      dirty     <= 1'b0;
      done_pend <= 1'b0;
      tag       <= '0;
      data      <= '0;
      pend      <= '0;
    end else begin
      if (state == DONE) done_pend <= 1'b0;
      else if (prim_done) done_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (fifo_ne) begin
            if (hit) begin
              data[head.bidx] <= head.color;
              dirty           <= 1'b1;
            end else begin
              pend <= head;
            end
          end
        end
        WB, FLUSH: dirty <= 1'b0;
        RDWAIT: begin
          data  <= rd_merge;
          tag   <= pend.word;
          valid <= 1'b1;
          dirty <= 1'b1;
        end
        DONE: valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: expected SRAM transactions and frame_done
// pulses are queued by the stimulus and checked by an independent monitor.
module tb_fb_pixel_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid, pix_color, prim_done;
  logic [18:0] pix_addr;
  logic        pix_ready, busy, frame_done, mem_ren, mem_wen;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = '0, mem_wdata;

  fb_pixel_writer #(.FIFO_DEPTH(4), .NUM_PIXELS(307200)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_addr(pix_addr),
    .pix_color(pix_color), .pix_ready(pix_ready), .prim_done(prim_done),
    .busy(busy), .frame_done(frame_done), .mem_addr(mem_addr), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // SRAM model with a bench-side preload port
  bit   [31:0] sram [16384];
  logic        init_we = 1'b0;
  logic [13:0] init_addr = '0;
  logic [31:0] init_data = '0;
  always @(posedge clk) begin
    if (init_we)      sram[init_addr] <= init_data;
    else if (mem_wen) sram[mem_addr]  <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr];
  end

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 frame_done
    logic [13:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t q[$];
  int  n_cmp = 0, n_mis = 0;
  bit  saw_full = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic exp_ev(input int kind, input logic [13:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic mon_ev(input int kind, input logic [13:0] a, input logic [31:0] d);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_mis++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%04h data 0x%08h, expected none", kind, a, d);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.addr != a || (kind == 1 && e.data != d)) begin
        n_mis++;
        $display("FAIL mem_event: got kind %0d addr 0x%04h data 0x%08h, expected kind %0d addr 0x%04h data 0x%08h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: strobes are registered-state decodes, so sampling on the falling edge is stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (!pix_ready) saw_full = 1;
      if (mem_ren && mem_wen) chk("strobe_overlap", 32'd1, 32'd0);
      if (mem_ren)    mon_ev(0, mem_addr, 32'd0);
      if (mem_wen)    mon_ev(1, mem_addr, mem_wdata);
      if (frame_done) mon_ev(2, 14'd0, 32'd0);
    end
  end

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic push(input logic [18:0] a, input logic c);
    int n = 0;
    pix_valid = 1'b1; pix_addr = a; pix_color = c;
    while (!pix_ready && n < 100) begin @(negedge clk); n++; end
    if (!pix_ready) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic pulse_done();
    prim_done = 1'b1;
    @(negedge clk);
    prim_done = 1'b0;
  endtask

  task automatic wait_fd(output int n);
    n = 1;
    while (!frame_done && n < 60) begin @(negedge clk); n++; end
    if (!frame_done) chk("frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd1);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_mem_ren"},   32'(mem_ren), 32'd0);
    chk({tag, "_mem_wen"},   32'(mem_wen), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic single_pixel(input string tag);
    int n;
    preload(14'h0C7A, 32'h0);
    exp_ev(0, 14'h0C7A, 32'h0);
    exp_ev(1, 14'h0C7A, 32'h0000_0020);
    exp_ev(2, 14'h0, 32'h0);
    push(19'h18F45, 1'b1);
    pulse_done();
    wait_fd(n);
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_sram"}, sram[14'h0C7A], 32'h0000_0020);
    chk({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; pix_valid = 1'b0; pix_addr = '0; pix_color = 1'b0; prim_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    single_pixel("single");

    // coalesce four pixels of word 0
    exp_ev(0, 14'd0, 32'h0);
    exp_ev(1, 14'd0, 32'h8000_0007);
    exp_ev(2, 14'd0, 32'h0);
    push(19'd0, 1'b1); push(19'd1, 1'b1); push(19'd2, 1'b1); push(19'd31, 1'b1);
    pulse_done();
    wait_fd(n);
    @(negedge clk);
    chk("coalesce_sram", sram[0], 32'h8000_0007);
    chk("coalesce_queue_empty", 32'(q.size()), 32'd0);

    // word crossing with a clear
    preload(14'd0, 32'hFFFF_FFFF);
    preload(14'd1, 32'h0);
    exp_ev(0, 14'd0, 32'h0);
    exp_ev(1, 14'd0, 32'hFFFF_FFF7);
    exp_ev(0, 14'd1, 32'h0);
    exp_ev(1, 14'd1, 32'h0000_0002);
    exp_ev(2, 14'd0, 32'h0);
    push(19'd3, 1'b0); push(19'd33, 1'b1);
    pulse_done();
    wait_fd(n);
    @(negedge clk);
    chk("cross_sram0", sram[0], 32'hFFFF_FFF7);
    chk("cross_sram1", sram[1], 32'h0000_0002);

    // out-of-range pixels are dropped
    exp_ev(2, 14'd0, 32'h0);
    push(19'd307200, 1'b1); push(19'd524287, 1'b1);
    pulse_done();
    wait_fd(n);
    chk("oor_fd_latency_le2", 32'(n <= 2), 32'd1);
    @(negedge clk);
    chk("oor_queue_empty", 32'(q.size()), 32'd0);

    // backpressure: six pixels in distinct words 2..7, bit k of word k
    saw_full = 0;
    exp_ev(0, 14'd2, 32'h0);
    for (int k = 3; k <= 7; k++) begin
      exp_ev(1, 14'(k - 1), 32'h1 << (k - 1));
      exp_ev(0, 14'(k), 32'h0);
    end
    exp_ev(1, 14'd7, 32'h80);
    exp_ev(2, 14'd0, 32'h0);
    for (int k = 2; k <= 7; k++) push(19'(k * 32 + k), 1'b1);
    pulse_done();
    wait_fd(n);
    @(negedge clk);
    chk("bp_ready_dropped", 32'(saw_full), 32'd1);
    for (int k = 2; k <= 7; k++) chk($sformatf("bp_sram%0d", k), sram[k], 32'h1 << k);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);

    // reset while in RDWAIT: the read happens, the write must not
    exp_ev(0, 14'd2, 32'h0);
    push(19'h40, 1'b1);
    n = 0;
    while (!mem_ren && n < 20) begin @(negedge clk); n++; end
    chk("rst_saw_read", 32'(mem_ren), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_queue_empty", 32'(q.size()), 32'd0);
    chk("midrst_sram2", sram[2], 32'h4);
    single_pixel("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Receiving end of the raster primitive pixel stream (circle/line generators).
- Accepts 19-bit linear pixel addresses (y*640+x) with a colour bit, buffers them in a small FIFO, and commits them to a 1-bpp frame buffer SRAM (32 pixels per word) by read-modify-write.
- A one-word write-back cache coalesces consecutive pixels that fall in the same word.
- On end-of-primitive, flushes the cache and pulses frame_done.

Parameters:
- FIFO_DEPTH, 4, pixel FIFO entries; power of 2, >=2.
- NUM_PIXELS, 307200, addresses >= this are discarded (640x480).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- pix_valid  in  1  pixel offered this cycle.
- pix_addr  in  19  linear pixel address.
- pix_color  in  1  1 = set bit, 0 = clear bit.
- pix_ready  out  1  FIFO can accept; transfer when pix_valid & pix_ready at posedge.
- prim_done  in  1  one-cycle pulse: primitive finished.
- busy  out  1  FIFO non-empty, or state != IDLE, or done pending.
- frame_done  out  1  one-cycle pulse after all pixels are committed.
- mem_addr  out  14  SRAM word address (pix_addr[18:5]).
- mem_ren  out  1  read strobe; data on mem_rdata exactly 1 cycle later.
- mem_rdata  in  32  read data.
- mem_wen  out  1  write strobe; write occurs at that posedge.
- mem_wdata  out  32  write data.

Behaviour:
- Reset values:
  - pix_ready=1; busy=0; frame_done=0.
  - mem_ren=0; mem_wen=0; mem_addr=0; mem_wdata=0.
  - FIFO empty; cache valid=0, dirty=0; done_pend=0; state IDLE.
- Reset mid-operation aborts everything. Pending dirty data is lost and no write is issued.
- FIFO:
  - pix_ready = (count != FIFO_DEPTH), from the registered count only. A same-cycle pop does not raise ready.
  - Push and pop in the same cycle are legal.
  - Pixels with pix_addr >= NUM_PIXELS are accepted (handshake completes) but not pushed.
- Bit mapping:
  - word = addr[18:5]; bit = addr[4:0].
  - Pixel bit index 0 is mem word bit 0.
- Cache: tag[13:0], data[31:0], valid, dirty.
- FSM states: IDLE, WB, READ, RDWAIT, FLUSH, DONE.
- IDLE, FIFO non-empty: pop the head into a pending register.
  - Hit (valid & tag==word): update data[bit] = color, set dirty, stay IDLE. One pixel per cycle.
  - Miss & dirty: go to WB.
  - Miss & clean: go to READ.
- IDLE, FIFO empty & done_pend:
  - dirty: go to FLUSH.
  - clean: go to DONE.
- WB: mem_wen=1, mem_addr=tag, mem_wdata=data; clear dirty; go to READ.
- READ: mem_ren=1, mem_addr=pending word; go to RDWAIT.
- RDWAIT:
  - data = mem_rdata with [bit] replaced by pending color.
  - tag = pending word; valid=1; dirty=1; go to IDLE.
- FLUSH: same strobes as WB; clear dirty; go to DONE.
- DONE:
  - frame_done=1 for this cycle only.
  - Clear done_pend and valid; go to IDLE.
- Latency:
  - Hit: 1 cycle/pixel.
  - Clean miss: 3 cycles (IDLE, READ, RDWAIT).
  - Dirty miss: 4 cycles.
- prim_done handling:
  - Latched into done_pend.
  - A pixel accepted in the same cycle as prim_done is included before frame_done.
  - prim_done while done_pend=1 is absorbed: one frame_done only.
  - Pixels accepted after prim_done (before DONE) are committed before frame_done.
- mem_ren and mem_wen are never asserted in the same cycle; strobes are registered-state decodes.
- Cache is invalidated after every frame_done, so external writers may modify SRAM between primitives.

Test Plan:
- Single pixel: rst, SRAM word 0x0C7A = 0x00000000, push addr 0x18F45 color 1, prim_done -> one read of 0x0C7A, one write of 0x0C7A data 0x00000020, frame_done pulse, busy low next cycle.
- Coalesce: push addrs 0,1,2,31 color 1 back-to-back into zero SRAM, then prim_done -> exactly 1 read and 1 write, word 0 = 0x80000007.
- Word crossing and clear: SRAM word 0 = 0xFFFFFFFF, word 1 = 0; push 3 (color 0), then 33 (color 1) -> WB word 0 = 0xFFFFFFF7 before read of word 1; flush word 1 = 0x00000002.
- Out of range: push 307200 and 524287, then prim_done -> no mem strobes, frame_done within 2 cycles.
- Backpressure: hold mem_rdata and stream 6 pixels in distinct words -> pix_ready drops after 4 outstanding; no pixel lost or duplicated; final SRAM matches the golden model.
- Reset mid-operation: assert rst in RDWAIT -> next cycle all outputs at reset values, no write issued, FIFO empty; a subsequent single-pixel test passes.
